// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB request arbiter.
// Holds the FSM state type and a helper that sizes the ACCESS wait counter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int unsigned DefaultAddrWidth = 32;
  localparam int unsigned DefaultDataWidth = 32;

  // Wait counter must hold TIMEOUT; keep at least one bit when the timeout is disabled.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx[IW-1:0]]) begin
        any                 = 1'b1;
        gnt[idx[IW-1:0]]    = 1'b1;
        gnt_idx             = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master port between NREQ valid/ready requesters with round-robin
// arbitration, APB SETUP/ACCESS sequencing, response return and stall timeout.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned AW      = DefaultAddrWidth,
  parameter int unsigned DW      = DefaultDataWidth,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ-1:0]  req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_err,
  output logic             PSEL,
  output logic             PENABLE,
  output logic             PWRITE,
  output logic [AW-1:0]    PADDR,
  output logic [DW-1:0]    PWDATA,
  input  logic [DW-1:0]    PRDATA,
  input  logic             PREADY,
  input  logic             PSLVERR
);

  localparam int unsigned IW        = $clog2(NREQ);
  localparam int unsigned CW        = cnt_width(TIMEOUT);
  localparam bit          TimeoutEn = (TIMEOUT != 0);
  // Count value seen on the TIMEOUT-th stalled ACCESS cycle.
  localparam logic [CW-1:0] CntLast = CW'(TimeoutEn ? TIMEOUT - 1 : 0);

  apb_state_t      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  rr_arbiter #(
    .N(NREQ)
  ) u_rr_arbiter (
    .req    (req_valid),
    .ptr    (ptr_q),
    .gnt    (arb_gnt),
    .gnt_idx(arb_idx),
    .any    (arb_any)
  );

  always_comb begin
    sel_addr  = req_addr[arb_idx*AW +: AW];
    sel_wdata = req_wdata[arb_idx*DW +: DW];
  end

  // Grants only surface in IDLE and never while reset is held.
  assign req_ready = (state_q == IDLE && !PRESET) ? arb_gnt : '0;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = req_write[arb_idx];
          paddr_d   = sel_addr;
          pwdata_d  = sel_wdata;
          owner_d   = arb_idx;
          ptr_d     = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end

      ACCESS: begin
        if (PREADY) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = NREQ'(1) << owner_q;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
        end else if (TimeoutEn && cnt_q == CntLast) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = NREQ'(1) << owner_q;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: arbitration table, directed timing cases,
// and a randomized run against a transaction-level reference model.
module tb_apb_req_arbiter;

  localparam int NREQ    = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic              PCLK;
  logic              PRESET;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              PSEL, PENABLE, PWRITE;
  logic [AW-1:0]     PADDR;
  logic [DW-1:0]     PWDATA;
  logic [DW-1:0]     PRDATA;
  logic              PREADY, PSLVERR;

  apb_req_arbiter #(
    .NREQ   (NREQ),
    .AW     (AW),
    .DW     (DW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge PCLK);
  endtask

  task automatic do_reset();
    PRESET    = 1'b1;
    req_valid = '0;
    step();
    step();
    PRESET = 1'b0;
    #1;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
  endtask

  // ---------------- reference model (transaction level) ----------------
  int              m_ptr, m_age, m_stall, m_owner;
  bit              m_busy;
  logic            m_write;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [NREQ-1:0] m_rsp_valid;
  logic            m_rsp_err;
  logic [DW-1:0]   m_rsp_rdata;

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] model_ready();
    int g;
    if (PRESET || m_busy) return '0;
    g = pick(req_valid, m_ptr);
    return (g < 0) ? '0 : NREQ'(1) << g;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_age = 0; m_stall = 0; m_owner = 0;
    m_write = 0; m_addr = '0; m_wdata = '0;
    m_rsp_valid = '0; m_rsp_err = 0; m_rsp_rdata = '0;
  endtask

  task automatic model_step();
    int g;
    if (PRESET) begin
      model_reset();
      return;
    end
    m_rsp_valid = '0;
    if (!m_busy) begin
      g = pick(req_valid, m_ptr);
      if (g >= 0) begin
        m_busy = 1; m_age = 1; m_stall = 0; m_owner = g;
        m_write = req_write[g];
        m_addr  = req_addr[g*AW +: AW];
        m_wdata = req_wdata[g*DW +: DW];
        m_ptr   = (g + 1) % NREQ;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (PREADY) begin
      m_busy = 0;
      m_rsp_valid = NREQ'(1) << m_owner;
      m_rsp_err   = PSLVERR;
      m_rsp_rdata = m_write ? '0 : PRDATA;
    end else begin
      m_stall++;
      if (TIMEOUT != 0 && m_stall == TIMEOUT) begin
        m_busy = 0;
        m_rsp_valid = NREQ'(1) << m_owner;
        m_rsp_err   = 1'b1;
        m_rsp_rdata = '0;
      end
    end
  endtask

  // ---------------- arbitration table ----------------
  typedef struct {
    logic [NREQ-1:0] valid;
    logic            wr;
    logic [DW-1:0]   prdata;
    logic            slverr;
    int              exp_idx;
    logic [DW-1:0]   exp_rdata;
  } vec_t;

  vec_t vecs[9];

  logic [NREQ-1:0] pend;
  logic [NREQ-1:0] exp_ready;
  int              stall_left;

  initial begin
    PRESET = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;

    // Pointer walks from 0 after reset; expected winners worked out by hand.
    vecs[0] = '{4'b1111, 1'b0, 32'hA0A0_0001, 1'b0,  0, 32'hA0A0_0001};
    vecs[1] = '{4'b0001, 1'b1, 32'h0000_5555, 1'b0,  0, 32'h0};
    vecs[2] = '{4'b1000, 1'b0, 32'h3333_0003, 1'b1,  3, 32'h3333_0003};
    vecs[3] = '{4'b0110, 1'b1, 32'h0000_7777, 1'b1,  1, 32'h0};
    vecs[4] = '{4'b0011, 1'b0, 32'hCAFE_0004, 1'b0,  0, 32'hCAFE_0004};
    vecs[5] = '{4'b1100, 1'b0, 32'hBEEF_0005, 1'b0,  2, 32'hBEEF_0005};
    vecs[6] = '{4'b0101, 1'b0, 32'h6666_0006, 1'b0,  0, 32'h6666_0006};
    vecs[7] = '{4'b0000, 1'b0, 32'h0,         1'b0, -1, 32'h0};
    vecs[8] = '{4'b0100, 1'b1, 32'h0000_8888, 1'b0,  2, 32'h0};

    step();
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW]  = 32'h1000 + 32'(i) * 32'h10;
      req_wdata[i*DW +: DW] = 32'hD000_0000 + 32'(i);
    end
    foreach (vecs[v]) begin
      req_valid = vecs[v].valid;
      req_write = {NREQ{vecs[v].wr}};
      PREADY = 1'b1; PRDATA = vecs[v].prdata; PSLVERR = vecs[v].slverr;
      #1;
      chk($sformatf("tbl%0d_ready", v), req_ready,
          (vecs[v].exp_idx < 0) ? 0 : (64'd1 << vecs[v].exp_idx));
      step();
      req_valid = '0;
      #1;
      if (vecs[v].exp_idx < 0) begin
        chk($sformatf("tbl%0d_nopsel", v), PSEL, 0);
        continue;
      end
      chk($sformatf("tbl%0d_setup_psel", v), {PSEL, PENABLE}, 2'b10);
      chk($sformatf("tbl%0d_paddr", v), PADDR, 32'h1000 + 32'(vecs[v].exp_idx) * 32'h10);
      chk($sformatf("tbl%0d_pwrite", v), PWRITE, vecs[v].wr);
      step(); #1;
      chk($sformatf("tbl%0d_access", v), {PSEL, PENABLE}, 2'b11);
      step(); #1;
      chk($sformatf("tbl%0d_rsp_valid", v), rsp_valid, 64'd1 << vecs[v].exp_idx);
      chk($sformatf("tbl%0d_rsp_rdata", v), rsp_rdata, vecs[v].exp_rdata);
      chk($sformatf("tbl%0d_rsp_err", v), rsp_err, vecs[v].slverr);
      chk($sformatf("tbl%0d_psel_drop", v), PSEL, 0);
    end

    // Zero-wait write from requester 0.
    do_reset();
    req_valid = 4'b0001; req_write = 4'b0001;
    req_addr[0 +: AW] = 32'h10; req_wdata[0 +: DW] = 32'hDEAD_BEEF;
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h5A5A_5A5A;
    #1 chk("wr_c0_ready", req_ready, 4'b0001);
    step(); req_valid = '0; #1;
    chk("wr_c1_ctl", {PSEL, PENABLE, PWRITE}, 3'b101);
    chk("wr_c1_paddr", PADDR, 32'h10);
    chk("wr_c1_pwdata", PWDATA, 32'hDEAD_BEEF);
    step(); #1;
    chk("wr_c2_ctl", {PSEL, PENABLE}, 2'b11);
    chk("wr_c2_pwdata", PWDATA, 32'hDEAD_BEEF);
    step(); #1;
    chk("wr_c3_ctl", {PSEL, PENABLE}, 2'b00);
    chk("wr_c3_rsp", {rsp_valid, rsp_err}, {4'b0001, 1'b0});
    chk("wr_c3_rdata", rsp_rdata, 0);

    // Read from requester 2 with three wait states.
    do_reset();
    req_valid = 4'b0100; req_write = 4'b0000; req_addr[2*AW +: AW] = 32'h20;
    PREADY = 1'b0; PRDATA = 32'hFFFF_FFFF;
    #1 chk("rd_c0_ready", req_ready, 4'b0100);
    for (int c = 1; c <= 5; c++) begin
      step();
      req_valid = '0;
      if (c == 5) begin PREADY = 1'b1; PRDATA = 32'h1234_5678; end
      #1;
      chk($sformatf("rd_c%0d_psel", c), PSEL, 1);
      chk($sformatf("rd_c%0d_norsp", c), rsp_valid, 0);
    end
    chk("rd_c5_paddr", PADDR, 32'h20);
    step(); #1;
    chk("rd_c6_rsp_valid", rsp_valid, 4'b0100);
    chk("rd_c6_rdata", rsp_rdata, 32'h1234_5678);
    chk("rd_c6_psel", PSEL, 0);

    // Timeout: requester 1 stalls forever, requester 2 waits behind it.
    do_reset();
    req_valid = 4'b0010; req_write = 4'b0000;
    req_addr[1*AW +: AW] = 32'h50; req_addr[2*AW +: AW] = 32'h60;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'hBAD0_BAD0;
    #1 chk("to_c0_ready", req_ready, 4'b0010);
    for (int c = 1; c <= 17; c++) begin
      step();
      if (c == 1) req_valid = '0;
      if (c == 5) req_valid = 4'b0100;
      #1;
      chk($sformatf("to_c%0d_psel", c), PSEL, 1);
      chk($sformatf("to_c%0d_norsp", c), rsp_valid, 0);
      if (c >= 5) chk($sformatf("to_c%0d_noready", c), req_ready, 0);
    end
    step(); #1;
    chk("to_c18_ctl", {PSEL, PENABLE}, 2'b00);
    chk("to_c18_rsp", {rsp_valid, rsp_err}, {4'b0010, 1'b1});
    chk("to_c18_rdata", rsp_rdata, 0);
    chk("to_c18_next_ready", req_ready, 4'b0100);

    // Reset during a wait state drops the transfer.
    do_reset();
    req_valid = 4'b1000; req_write = 4'b0000;
    req_addr[3*AW +: AW] = 32'h30; req_addr[0 +: AW] = 32'h40;
    PREADY = 1'b0;
    #1 chk("rm_c0_ready", req_ready, 4'b1000);
    step(); req_valid = '0;
    step(); #1 chk("rm_c2_penable", PENABLE, 1);
    step(); PRESET = 1'b1; req_valid = 4'b1111;
    #1 chk("rm_c3_ready_in_rst", req_ready, 0);
    step(); #1;
    chk("rm_c4_ctl", {PSEL, PENABLE, PWRITE}, 0);
    chk("rm_c4_paddr", PADDR, 0);
    chk("rm_c4_pwdata", PWDATA, 0);
    chk("rm_c4_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    chk("rm_c4_ready_in_rst", req_ready, 0);
    PRESET = 1'b0;
    #1 chk("rm_c4_ready_after", req_ready, 4'b0001);
    step(); req_valid = '0; PREADY = 1'b1; #1;
    chk("rm_c5_norsp", rsp_valid, 0);
    chk("rm_c5_paddr", PADDR, 32'h40);
    step(); step(); #1;
    chk("rm_c7_rsp", rsp_valid, 4'b0001);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    pend = '0;
    stall_left = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      PRESET = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]               = 1'b1;
          req_write[i]          = 1'($urandom_range(0, 1));
          req_addr[i*AW +: AW]  = $urandom;
          req_wdata[i*DW +: DW] = $urandom;
        end
      end
      req_valid = pend;
      if (stall_left > 0) begin
        stall_left--;
        PREADY = 1'b0;
      end else if ($urandom_range(0, 79) == 0) begin
        stall_left = 20;
        PREADY = 1'b0;
      end else begin
        PREADY = ($urandom_range(0, 3) != 0);
      end
      PRDATA  = $urandom;
      PSLVERR = ($urandom_range(0, 7) == 0);
      #1;
      exp_ready = model_ready();
      chk("rnd_ready", req_ready, exp_ready);
      chk("rnd_psel", PSEL, m_busy);
      chk("rnd_penable", PENABLE, m_busy && m_age >= 2);
      chk("rnd_rsp_valid", rsp_valid, m_rsp_valid);
      if (m_busy) begin
        chk("rnd_paddr", PADDR, m_addr);
        chk("rnd_pwrite", PWRITE, m_write);
        chk("rnd_pwdata", PWDATA, m_wdata);
      end
      if (m_rsp_valid != 0) begin
        chk("rnd_rsp_rdata", rsp_rdata, m_rsp_rdata);
        chk("rnd_rsp_err", rsp_err, m_rsp_err);
      end
      model_step();
      pend = pend & ~exp_ready;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
